// File: rtl/ring_delay_line_multi.sv
// ---------------------------------------------------------------------------
// ring_delay_line_multi
//
// Multi-lane, runtime-programmable sample delay line. All lanes share one
// ring-buffer pointer, so every lane is delayed by the same number of enabled
// samples and the lanes stay aligned. The delay D is latched from depth_i on
// a flush and is clamped to 1..MAX_DEPTH. A fill counter holds back the output
// until D samples have been stored. Until then the output is zero and the
// valid flag is low, so stale storage from an earlier run never reaches
// data_o.
//
// Ports:
//   clk_i     clock, all logic on the rising edge
//   rst_ni    asynchronous active-low reset (acts like a flush to MAX_DEPTH)
//   enable_i  advance: read one sample set and write one sample set
//   flush_i   synchronous clear; latches depth_i (wins over enable_i)
//   depth_i   requested delay D, sampled only while flush_i=1
//   data_i    input samples, lane c at bits [c*WIDTH +: WIDTH]
//   data_o    delayed samples (registered), zero until valid
//   valid_o   data_o holds a genuine delayed sample
//   fill_o    enabled samples stored since flush/reset, saturates at D
// ---------------------------------------------------------------------------
module ring_delay_line_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int MAX_DEPTH = 8,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic [DEPTH_W-1:0]           depth_i,
  input  logic [CHANNELS*WIDTH-1:0]    data_i,
  output logic [CHANNELS*WIDTH-1:0]    data_o,
  output logic                         valid_o,
  output logic [DEPTH_W-1:0]           fill_o
);

  localparam int DATA_W = CHANNELS * WIDTH;
  localparam int PTR_W  = $clog2(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  // Storage is deliberately not reset; the fill gate hides its contents.
  logic [DATA_W-1:0]  mem_q [MAX_DEPTH];

  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [DEPTH_W-1:0] fill_q,  fill_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic               valid_q, valid_d;

  logic               full;
  logic               lastSlot;
  logic               advance;
  logic [DEPTH_W-1:0] depthClamped;

  // The buffer is "full" once D samples are stored; only then does the
  // slot under the pointer hold the sample from exactly D enables ago.
  assign full     = (fill_q == depth_q);
  assign lastSlot = (DEPTH_W'(ptr_q) == (depth_q - DEPTH_W'(1)));
  assign advance  = enable_i & ~flush_i;

  // Depth request limited to the legal range 1..MAX_DEPTH.
  always_comb begin
    depthClamped = depth_i;
    if (depth_i == '0) begin
      depthClamped = DEPTH_W'(1);
    end else if (depth_i > MAX_D) begin
      depthClamped = MAX_D;
    end
  end

  // Next-state logic. Flush takes priority and discards that cycle's data_i.
  // On an enable the old slot content is read before it is overwritten, and
  // the pointer wraps at D-1 so entries beyond D are never touched.
  always_comb begin
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    depth_d = depth_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      ptr_d   = '0;
      fill_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
      depth_d = depthClamped;
    end else if (enable_i) begin
      data_d  = full ? mem_q[ptr_q] : '0;
      valid_d = full;
      ptr_d   = lastSlot ? '0 : (ptr_q + PTR_W'(1));
      fill_d  = full ? fill_q : (fill_q + DEPTH_W'(1));
    end
  end

  // Control and output registers; reset is equivalent to a flush to MAX_DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      fill_q  <= '0;
      depth_q <= MAX_D;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      depth_q <= depth_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Sample storage: one write per enabled, non-flushed cycle.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign fill_o  = fill_q;

endmodule
